// File: rtl/bus_arb_pkg.sv
// Shared types and default widths for the busctl round-robin arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} bus_arb_state_t;

  localparam int unsigned BUS_ADDR_W = 8;
  localparam int unsigned BUS_DATA_W = 8;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req bit searching upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one busctl between NUM_REQ requesters.
// Optional grant locking is enabled with the BUS_ARB_LOCK_EN macro.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = BUS_ADDR_W,
  parameter int unsigned DATA_W  = BUS_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef BUS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      bus_write_en,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic [DATA_W-1:0]         bus_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  bus_arb_state_t   state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             bus_write_en_q, bus_write_en_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic [IDX_W-1:0] rr_base;
  logic [IDX_W-1:0] pick_grant;
  logic             pick_valid;
  logic             take;
  logic [IDX_W-1:0] sel;

`ifdef BUS_ARB_LOCK_EN
  logic lock_q, lock_d;

  // A lapsed lock resumes round-robin after the lock holder, not after the
  // stale last_grant that was frozen while the lock was held.
  assign rr_base = lock_q ? grant_q : last_grant_q;
`else
  assign rr_base = last_grant_q;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req),
    .last_grant (rr_base),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      last_grant_q   <= IDX_W'(NUM_REQ - 1);
      bus_write_en_q <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
`ifdef BUS_ARB_LOCK_EN
      lock_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      bus_write_en_q <= bus_write_en_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
`ifdef BUS_ARB_LOCK_EN
      lock_q         <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    bus_write_en_d = bus_write_en_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    take           = 1'b0;
    sel            = pick_grant;
`ifdef BUS_ARB_LOCK_EN
    lock_d         = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        take = pick_valid;
`ifdef BUS_ARB_LOCK_EN
        if (lock_q && req[grant_q] && req_lock[grant_q]) begin
          take = 1'b1;
          sel  = grant_q;
        end
        lock_d = 1'b0;
`endif
        if (take) begin
          grant_d        = sel;
          bus_write_en_d = req_we[sel];
          bus_addr_d     = req_addr[32'(sel)*ADDR_W +: ADDR_W];
          bus_wdata_d    = req_wdata[32'(sel)*DATA_W +: DATA_W];
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus_write_en_d = 1'b0;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
`ifdef BUS_ARB_LOCK_EN
        if (req_lock[grant_q] && req[grant_q]) begin
          lock_d       = 1'b1;
          last_grant_d = last_grant_q;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state_q == ST_RESP) ack[grant_q] = 1'b1;
    rdata = bus_rdata;
  end

  assign bus_write_en = bus_write_en_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;

endmodule
